hub75_scan_ctrl: RTL

//  Parametrised HUB75 LED-matrix scan controller with binary-code-modulation (BCM) brightness.
//  For each row it shifts PLANES bit-planes of NCOLS pixels, then blanks, latches and displays each plane
//  for BASE_ON<<plane clocks. The display time of one plane overlaps the shift of the next.

---
 rtl/hub75_scan_ctrl_pkg.sv | 34 +++
 rtl/hub75_scan_ctrl_dly_timer.sv | 27 ++
 rtl/hub75_scan_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared types and width helpers for the HUB75 scan controller.
package hub75_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_BLANK = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  function automatic int min1_clog2(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int col_w(input int ncols);
    return min1_clog2(ncols);
  endfunction

  function automatic int plane_w(input int planes);
    return min1_clog2(planes);
  endfunction

  // Wide enough to hold the longest plane on-time itself.
  function automatic int on_w(input int base_on, input int planes);
    return $clog2(base_on << (planes - 1)) + 1;
  endfunction

  function automatic int wait_w(input int wait_cycles);
    return min1_clog2(wait_cycles);
  endfunction

endpackage

// File: rtl/hub75_scan_ctrl_dly_timer.sv
// Loadable down-counter; done is high once the count reaches zero.
module hub75_scan_ctrl_dly_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         enb_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (enb_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: shifts each row-plane while the previous plane is displayed for its BCM weight.
// Handshake: a column advances from phase A only when pix_rdy=1 is sampled while pix_req=1; no other backpressure exists.
module hub75_scan_ctrl
  import hub75_scan_ctrl_pkg::*;
#(
  parameter int NCOLS       = 32,
  parameter int ROW_BITS    = 3,
  parameter int PLANES      = 4,
  parameter int WAIT_CYCLES = 4,
  parameter int BASE_ON     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enb,
  input  logic                              pix_rdy,
  output logic                              pix_req,
  output logic [col_w(NCOLS)-1:0]           col_addr,
  output logic [ROW_BITS-1:0]               load_row,
  output logic [plane_w(PLANES)-1:0]        load_plane,
  output logic                              sclk,
  output logic                              lat,
  output logic                              blank,
  output logic [ROW_BITS-1:0]               row_addr,
  output logic                              frame_done,
  output state_e                            dbg_state
);

  localparam int CW = col_w(NCOLS);
  localparam int PW = plane_w(PLANES);
  localparam int OW = on_w(BASE_ON, PLANES);
  localparam int TW = wait_w(WAIT_CYCLES);

  state_e                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  phase_q, phase_d;
  logic                  shifted_q, shifted_d;
  logic [ROW_BITS-1:0]   load_row_q, load_row_d;
  logic [ROW_BITS-1:0]   row_addr_q, row_addr_d;
  logic [PW-1:0]         load_plane_q, load_plane_d;
  logic [PW-1:0]         disp_plane_q, disp_plane_d;
  logic                  disp_valid_q, disp_valid_d;
  logic [OW-1:0]         on_cnt_q, on_cnt_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tmr_load, tmr_enb, tmr_done;
  logic [OW-1:0]         on_limit;
  logic                  on_done, last_b, latch_exit;

  assign on_limit   = OW'(BASE_ON) << disp_plane_q;
  // True when the current plane's on-time ends with this clock (or nothing is displayed).
  assign on_done    = !disp_valid_q || (on_cnt_q >= (on_limit - OW'(1)));
  assign last_b     = phase_q && !shifted_q && (col_q == CW'(NCOLS - 1));
  assign latch_exit = (state_q == ST_LATCH) && tmr_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      phase_q      <= 1'b0;
      shifted_q    <= 1'b0;
      load_row_q   <= '0;
      row_addr_q   <= '0;
      load_plane_q <= '0;
      disp_plane_q <= '0;
      disp_valid_q <= 1'b0;
      on_cnt_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      phase_q      <= phase_d;
      shifted_q    <= shifted_d;
      load_row_q   <= load_row_d;
      row_addr_q   <= row_addr_d;
      load_plane_q <= load_plane_d;
      disp_plane_q <= disp_plane_d;
      disp_valid_q <= disp_valid_d;
      on_cnt_q     <= on_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enb) state_d = ST_SHIFT;
      ST_SHIFT: if ((last_b || shifted_q) && on_done) state_d = ST_BLANK;
      ST_BLANK: if (tmr_done) state_d = ST_LATCH;
      ST_LATCH: if (tmr_done) state_d = enb ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign tmr_load = ((state_q == ST_SHIFT) && (state_d == ST_BLANK)) ||
                    ((state_q == ST_BLANK) && (state_d == ST_LATCH));
  assign tmr_enb  = (state_q == ST_BLANK) || (state_q == ST_LATCH);

  hub75_scan_ctrl_dly_timer #(.W(TW)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (TW'(WAIT_CYCLES - 1)),
    .enb_i      (tmr_enb),
    .done_o     (tmr_done)
  );

  always_comb begin
    col_d        = col_q;
    phase_d      = phase_q;
    shifted_d    = shifted_q;
    load_row_d   = load_row_q;
    row_addr_d   = row_addr_q;
    load_plane_d = load_plane_q;
    disp_plane_d = disp_plane_q;
    disp_valid_d = disp_valid_q;
    on_cnt_d     = on_cnt_q;
    frame_done_d = 1'b0;

    if (state_q == ST_SHIFT) begin
      if (on_cnt_q != '1) on_cnt_d = on_cnt_q + OW'(1);
      if (!shifted_q) begin
        if (!phase_q) begin
          if (pix_rdy) phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col_q == CW'(NCOLS - 1)) begin
            col_d     = '0;
            shifted_d = 1'b1;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
    end

    if (latch_exit) begin
      row_addr_d   = load_row_q;
      disp_plane_d = load_plane_q;
      disp_valid_d = enb;
      on_cnt_d     = '0;
      shifted_d    = 1'b0;
      phase_d      = 1'b0;
      col_d        = '0;
      if (load_plane_q == PW'(PLANES - 1)) begin
        load_plane_d = '0;
        load_row_d   = load_row_q + ROW_BITS'(1);
        if (load_row_q == '1) frame_done_d = 1'b1;
      end else begin
        load_plane_d = load_plane_q + PW'(1);
      end
    end
  end

  always_comb begin
    sclk       = (state_q == ST_SHIFT) && phase_q && !shifted_q;
    pix_req    = (state_q == ST_SHIFT) && !phase_q && !shifted_q;
    lat        = (state_q == ST_LATCH);
    blank      = !((state_q == ST_SHIFT) && disp_valid_q && (on_cnt_q < on_limit));
    col_addr   = col_q;
    load_row   = load_row_q;
    load_plane = load_plane_q;
    row_addr   = row_addr_q;
    frame_done = frame_done_q;
    dbg_state  = state_q;
  end

endmodule
